wb_intercon_tmo: RTL and testbench

- Parametrised single-master, N-slave Wishbone interconnect; successor to the current fixed-width combinational intercon.
- Sits between the multi-cycle CPU bus port and the slaves (RAM, disk, VRAM, keyboard, counter, and later additions).
- Adds registered request/response staging, a configurable slave count and address field, and a bus-error response.
- A bus error is returned for unmapped addresses and for slaves that never ACK (timeout watchdog), so a missing slave cannot hang the CPU.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_addr_decode.sv | 28 ++
 rtl/wb_intercon_tmo.sv | 125 ++++++++++++
 tb/tb_wb_intercon_tmo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, default error data and the
// interconnect state encoding.
package wb_pkg;
  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam logic [WB_DW-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } wb_state_e;
endpackage

// File: rtl/wb_addr_decode.sv
// Combinational slave decoder: the select field of the address becomes a one-hot
// slave select plus a flag that says whether the field names an existing slave.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int N_SLAVES = 5,
  parameter int SEL_LSB  = 28,
  parameter int SEL_BITS = 4
) (
  input  logic [WB_AW-1:0]    addr,
  output logic [N_SLAVES-1:0] sel,
  output logic                valid
);
  logic [SEL_BITS-1:0] idx;
  logic                unused_addr;

  assign idx         = addr[SEL_LSB +: SEL_BITS];
  assign valid       = (32'(idx) < N_SLAVES);
  // Only the select field matters here; the other address bits belong to the slaves.
  assign unused_addr = ^addr;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      sel[i] = valid && (32'(idx) == i);
    end
  end
endmodule

// File: rtl/wb_intercon_tmo.sv
// Single-master, N-slave Wishbone interconnect with registered staging, an
// unmapped-address error and a no-ACK timeout watchdog.
module wb_intercon_tmo
  import wb_pkg::*;
#(
  parameter int          N_SLAVES   = 5,
  parameter int          SEL_LSB    = 28,
  parameter int          SEL_BITS   = 4,
  parameter int          TMO_CYCLES = 255,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
  input  logic                     clk,
  input  logic                     RSTN,
  input  logic                     master_STB,
  input  logic                     master_WE,
  input  logic [31:0]              master_ADDR,
  input  logic [31:0]              master_DAT_O,
  output logic [31:0]              master_DAT_I,
  output logic                     master_ACK,
  output logic                     master_ERR,
  output logic [N_SLAVES-1:0]      slave_STB,
  output logic [N_SLAVES-1:0]      slave_WE,
  output logic [31:0]              slave_ADDR,
  output logic [31:0]              slave_DAT_I,
  input  logic [32*N_SLAVES-1:0]   slave_DAT_O,
  input  logic [N_SLAVES-1:0]      slave_ACK,
  output logic [7:0]               tmo_count
);
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

  wb_state_e           state_q;
  logic [N_SLAVES-1:0] sel_q;
  logic                we_q;
  logic [15:0]         cnt_q;

  logic [N_SLAVES-1:0] dec_sel;
  logic                dec_valid;
  logic [31:0]         rd_mux;
  logic                ack_hit;

  wb_addr_decode #(
    .N_SLAVES (N_SLAVES),
    .SEL_LSB  (SEL_LSB),
    .SEL_BITS (SEL_BITS)
  ) u_dec (
    .addr  (master_ADDR),
    .sel   (dec_sel),
    .valid (dec_valid)
  );

  // Only the latched selection can complete a transfer; stray ACKs fall out here.
  assign ack_hit = |(slave_ACK & sel_q);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) rd_mux = rd_mux | slave_DAT_O[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      master_DAT_I <= '0;
      master_ACK   <= 1'b0;
      master_ERR   <= 1'b0;
      slave_STB    <= '0;
      slave_WE     <= '0;
      slave_ADDR   <= '0;
      slave_DAT_I  <= '0;
      tmo_count    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (master_STB) begin
            slave_ADDR  <= master_ADDR;
            slave_DAT_I <= master_DAT_O;
            we_q        <= master_WE;
            sel_q       <= dec_sel;
            if (dec_valid) begin
              slave_STB <= dec_sel;
              slave_WE  <= master_WE ? dec_sel : '0;
              cnt_q     <= '0;
              state_q   <= BUSY;
            end else begin
              master_DAT_I <= ERR_DATA;
              master_ERR   <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        BUSY: begin
          // ACK is tested first so it wins over a timeout in the same cycle.
          if (ack_hit) begin
            if (!we_q) master_DAT_I <= rd_mux;
            slave_STB  <= '0;
            slave_WE   <= '0;
            master_ACK <= 1'b1;
            state_q    <= DONE;
          end else if (cnt_q == TMO_LAST) begin
            slave_STB    <= '0;
            slave_WE     <= '0;
            master_DAT_I <= ERR_DATA;
            master_ERR   <= 1'b1;
            if (tmo_count != 8'hFF) tmo_count <= tmo_count + 8'd1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DONE: begin
          if (!master_STB) begin
            master_ACK <= 1'b0;
            master_ERR <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_intercon_tmo.sv
// Bench for wb_intercon_tmo: transaction-level timeline model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_intercon_tmo;
  localparam int NS  = 5;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              RSTN;
  logic              master_STB;
  logic              master_WE;
  logic [31:0]       master_ADDR;
  logic [31:0]       master_DAT_O;
  logic [31:0]       master_DAT_I;
  logic              master_ACK;
  logic              master_ERR;
  logic [NS-1:0]     slave_STB;
  logic [NS-1:0]     slave_WE;
  logic [31:0]       slave_ADDR;
  logic [31:0]       slave_DAT_I;
  logic [32*NS-1:0]  slave_DAT_O;
  logic [NS-1:0]     slave_ACK;
  logic [7:0]        tmo_count;

  always #5 clk = ~clk;

  wb_intercon_tmo #(
    .N_SLAVES   (NS),
    .SEL_LSB    (28),
    .SEL_BITS   (4),
    .TMO_CYCLES (TMO),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk          (clk),
    .RSTN         (RSTN),
    .master_STB   (master_STB),
    .master_WE    (master_WE),
    .master_ADDR  (master_ADDR),
    .master_DAT_O (master_DAT_O),
    .master_DAT_I (master_DAT_I),
    .master_ACK   (master_ACK),
    .master_ERR   (master_ERR),
    .slave_STB    (slave_STB),
    .slave_WE     (slave_WE),
    .slave_ADDR   (slave_ADDR),
    .slave_DAT_I  (slave_DAT_I),
    .slave_DAT_O  (slave_DAT_O),
    .slave_ACK    (slave_ACK),
    .tmo_count    (tmo_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Current transaction, as a timeline of edge numbers:
  // E = request accepted, Ec = completion, Ed = master_STB seen low again.
  bit          tr_active = 0;
  bit          tr_valid, tr_we, tr_err;
  int          tr_E, tr_Ec, tr_Ed, tr_idx;
  logic [31:0] tr_addr, tr_wdat, tr_rd;

  logic [31:0] m_addr = '0, m_wdat = '0, m_rd = '0;
  int          m_tmo  = 0;
  bit          chk_en = 0;
  bit          stray_on = 0;

  int          stb_cycles, ack_cycles, err_cycles;
  logic [NS-1:0] we_seen;

  always @(negedge clk) begin : cmp
    bit          busy, done;
    logic [NS-1:0] e_stb, e_we;
    if (chk_en) begin
      busy = tr_active && tr_valid && cyc >= tr_E && cyc < tr_Ec;
      done = tr_active && cyc >= tr_Ec && cyc < tr_Ed;
      if (tr_active && cyc == tr_E) begin
        m_addr = tr_addr;
        m_wdat = tr_wdat;
      end
      if (tr_active && cyc == tr_Ec) begin
        if (tr_err) m_rd = 32'hDEAD_BEEF;
        else if (!tr_we) m_rd = tr_rd;
        if (tr_err && tr_valid) m_tmo = (m_tmo >= 255) ? 255 : m_tmo + 1;
      end
      e_stb = busy ? (NS'(1) << tr_idx) : '0;
      e_we  = (busy && tr_we) ? (NS'(1) << tr_idx) : '0;
      check("slave_STB",    32'(slave_STB),  32'(e_stb));
      check("slave_WE",     32'(slave_WE),   32'(e_we));
      check("master_ACK",   32'(master_ACK), 32'(done && !tr_err));
      check("master_ERR",   32'(master_ERR), 32'(done && tr_err));
      check("master_DAT_I", master_DAT_I,    m_rd);
      check("slave_ADDR",   slave_ADDR,      m_addr);
      check("slave_DAT_I",  slave_DAT_I,     m_wdat);
      check("tmo_count",    32'(tmo_count),  32'(m_tmo));
      if (slave_STB != '0) stb_cycles++;
      if (slave_WE != '0)  we_seen = slave_WE;
      if (master_ACK)      ack_cycles++;
      if (master_ERR)      err_cycles++;
    end
  end

  task automatic drive_slaves(input bit valid, input int idx, input logic [31:0] rd,
                              input bit win, input bit hit);
    for (int i = 0; i < NS; i++) begin
      if (valid && i == idx) begin
        slave_DAT_O[32*i +: 32] = rd;
        slave_ACK[i] = win ? hit : ($urandom_range(0, 3) == 0);
      end else begin
        slave_DAT_O[32*i +: 32] = $urandom;
        slave_ACK[i] = stray_on ? 1'b1 : ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic do_reset_pulse();
    chk_en    = 0;
    tr_active = 0;
    RSTN      = 1'b0;
    #1;
    check("rst slave_STB",    32'(slave_STB),  32'h0);
    check("rst slave_WE",     32'(slave_WE),   32'h0);
    check("rst master_ACK",   32'(master_ACK), 32'h0);
    check("rst master_ERR",   32'(master_ERR), 32'h0);
    check("rst master_DAT_I", master_DAT_I,    32'h0);
    check("rst tmo_count",    32'(tmo_count),  32'h0);
    @(negedge clk);
    RSTN       = 1'b1;
    master_STB = 1'b0;
    m_addr = '0; m_wdat = '0; m_rd = '0; m_tmo = 0;
    @(posedge clk); #1;
    chk_en = 1;
  endtask

  // w: extra wait before the selected slave ACKs (-1 = never); h: cycles master_STB
  // is held after completion; g: idle gap after; abort: reset pulse this many edges after E.
  task automatic do_txn(input logic [31:0] addr, input bit we, input logic [31:0] wdat,
                        input int w, input int h, input int g, input logic [31:0] rd,
                        input int abort);
    int E, Ea, idx;
    bit valid;
    E     = cyc + 1;
    idx   = int'(addr[31:28]);
    valid = (idx < NS);
    Ea    = (w < 0) ? E + TMO + 100 : E + 1 + w;
    tr_E = E; tr_valid = valid; tr_idx = idx; tr_we = we;
    tr_addr = addr; tr_wdat = wdat; tr_rd = rd;
    if (!valid) begin
      tr_Ec = E; tr_err = 1;
    end else if (Ea <= E + TMO) begin
      tr_Ec = Ea; tr_err = 0;
    end else begin
      tr_Ec = E + TMO; tr_err = 1;
    end
    tr_Ed = tr_Ec + 1 + h;
    tr_active = 1;
    stb_cycles = 0; ack_cycles = 0; err_cycles = 0; we_seen = '0;
    for (int e = E; e <= tr_Ed; e++) begin
      if (abort > 0 && e == E + abort) begin
        check("STB before reset", 32'(slave_STB), 32'(NS'(1) << idx));
        do_reset_pulse();
        return;
      end
      master_STB = (e < tr_Ed);
      if (e == E) begin
        master_ADDR = addr; master_WE = we; master_DAT_O = wdat;
      end else begin
        master_ADDR = $urandom; master_WE = 1'($urandom); master_DAT_O = $urandom;
      end
      drive_slaves(valid, idx, rd, (e >= E + 1) && (e <= E + TMO), e == Ea);
      @(posedge clk); #1;
    end
    for (int k = 0; k < g; k++) begin
      master_STB = 1'b0;
      drive_slaves(1'b0, 0, '0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_txns(input int n);
    logic [31:0] a;
    int w;
    for (int k = 0; k < n; k++) begin
      a = $urandom;
      a[31:28] = 4'($urandom_range(0, 7));
      w = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 9));
      do_txn(a, 1'($urandom), $urandom, w, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), $urandom, 0);
    end
  endtask

  initial begin
    RSTN = 1'b0; master_STB = 1'b0; master_WE = 1'b0;
    master_ADDR = '0; master_DAT_O = '0; slave_DAT_O = '0; slave_ACK = '0;
    #3;
    check("reset master_DAT_I", master_DAT_I, 32'h0);
    check("reset ACK/ERR", {30'h0, master_ACK, master_ERR}, 32'h0);
    check("reset slave_STB", 32'(slave_STB), 32'h0);
    check("reset tmo_count", 32'(tmo_count), 32'h0);
    @(negedge clk); RSTN = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;

    // Zero-wait read from slave 0
    do_txn(32'h0000_0010, 1'b0, 32'h0, 0, 2, 1, 32'h1234_5678, 0);
    check("t1 stb_cycles", 32'(stb_cycles), 32'd1);
    check("t1 ack_cycles", 32'(ack_cycles), 32'd3);
    check("t1 rdata", master_DAT_I, 32'h1234_5678);

    // Write to slave 2, three wait cycles
    do_txn(32'h2000_0040, 1'b1, 32'hA5A5_A5A5, 3, 0, 0, 32'h5555_0000, 0);
    check("t2 we_seen", 32'(we_seen), 32'h4);
    check("t2 stb_cycles", 32'(stb_cycles), 32'd4);
    check("t2 ack_cycles", 32'(ack_cycles), 32'd1);
    check("t2 slave_DAT_I", slave_DAT_I, 32'hA5A5_A5A5);
    check("t2 rdata kept", master_DAT_I, 32'h1234_5678);

    // Unmapped slave index 7
    do_txn(32'h7000_0000, 1'b0, 32'h0, 0, 1, 0, 32'h0, 0);
    check("t3 rdata", master_DAT_I, 32'hDEAD_BEEF);
    check("t3 stb_cycles", 32'(stb_cycles), 32'd0);
    check("t3 ack_cycles", 32'(ack_cycles), 32'd0);
    check("t3 err_cycles", 32'(err_cycles), 32'd2);

    // Slave 3 never ACKs
    do_txn(32'h3000_0000, 1'b0, 32'h0, -1, 0, 0, 32'h3333_3333, 0);
    check("t4 stb_cycles", 32'(stb_cycles), 32'd8);
    check("t4 err_cycles", 32'(err_cycles), 32'd1);
    check("t4 tmo_count", 32'(tmo_count), 32'd1);
    check("t4 rdata", master_DAT_I, 32'hDEAD_BEEF);
    for (int k = 0; k < 299; k++)
      do_txn(32'h3000_0000, 1'($urandom), $urandom, -1, int'($urandom_range(0, 1)), 0, $urandom, 0);
    check("t4 tmo saturated", 32'(tmo_count), 32'd255);

    rand_txns(150);

    // Stray ACKs everywhere, selected slave ACKs on the timeout cycle
    stray_on = 1;
    do_txn(32'h1000_0008, 1'b0, 32'h0, TMO - 1, 0, 0, 32'hC0FF_EE01, 0);
    stray_on = 0;
    check("t5 ack_cycles", 32'(ack_cycles), 32'd1);
    check("t5 err_cycles", 32'(err_cycles), 32'd0);
    check("t5 stb_cycles", 32'(stb_cycles), 32'd8);
    check("t5 rdata", master_DAT_I, 32'hC0FF_EE01);

    // Reset during BUSY, then a normal read
    do_txn(32'h3000_0100, 1'b1, 32'h1111_2222, -1, 0, 0, 32'h0, 3);
    do_txn(32'h0000_0020, 1'b0, 32'h0, 1, 0, 1, 32'h0BAD_F00D, 0);
    check("t6 rdata", master_DAT_I, 32'h0BAD_F00D);
    check("t6 ack_cycles", 32'(ack_cycles), 32'd1);
    check("t6 tmo_count", 32'(tmo_count), 32'd0);

    rand_txns(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
